// File: rtl/ucode_sequencer.sv
// Microcode sequencer: walks microsteps 0..7 of the current opcode, addresses the
// control ROM with {flag_z, flag_c, opcode, step} and gates the ROM word onto ctrl.
module ucode_sequencer #(
  parameter bit EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step_req,
  input  logic [3:0]  opcode,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic [8:0]  ucode_addr,
  input  logic [15:0] ucode_data,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        flag_z,
  output logic        flag_c,
  output logic        halted,
  output logic        instr_done,
  output logic [7:0]  instr_count
);

  localparam int HLT_BIT = 15;
  localparam int FI_BIT  = 0;

  logic [2:0] step_q, step_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_c_q, flag_c_d;
  logic       halted_q, halted_d;
  logic       instr_done_q, instr_done_d;
  logic [7:0] instr_count_q, instr_count_d;
  logic       step_req_q, step_req_d;

  logic step_pulse;
  logic active;
  logic last_step;
  logic hlt;
  logic fi;

  always_comb begin
    step_pulse = step_req & ~step_req_q;
    active     = ~halted_q & (run | step_pulse);
    hlt        = ucode_data[HLT_BIT];
    fi         = ucode_data[FI_BIT];
    // An all-zero word can only end an instruction once the fetch steps are done.
    last_step  = (step_q == 3'd7) ||
                 (EARLY_END && (step_q >= 3'd2) && (ucode_data == 16'h0000));
  end

  always_comb begin
    step_d        = step_q;
    flag_z_d      = flag_z_q;
    flag_c_d      = flag_c_q;
    halted_d      = halted_q;
    instr_done_d  = 1'b0;
    instr_count_d = instr_count_q;
    step_req_d    = step_req;

    if (active) begin
      if (fi) begin
        flag_z_d = alu_zero;
        flag_c_d = alu_carry;
      end
      if (hlt) begin
        halted_d = 1'b1;
      end else if (last_step) begin
        step_d        = 3'd0;
        instr_done_d  = 1'b1;
        instr_count_d = instr_count_q + 8'd1;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q        <= 3'd0;
      flag_z_q      <= 1'b0;
      flag_c_q      <= 1'b0;
      halted_q      <= 1'b0;
      instr_done_q  <= 1'b0;
      instr_count_q <= 8'd0;
      step_req_q    <= 1'b0;
    end else begin
      step_q        <= step_d;
      flag_z_q      <= flag_z_d;
      flag_c_q      <= flag_c_d;
      halted_q      <= halted_d;
      instr_done_q  <= instr_done_d;
      instr_count_q <= instr_count_d;
      step_req_q    <= step_req_d;
    end
  end

  assign ucode_addr  = {flag_z_q, flag_c_q, opcode, step_q};
  assign ctrl        = (active && !reset) ? ucode_data : 16'h0000;
  assign step        = step_q;
  assign flag_z      = flag_z_q;
  assign flag_c      = flag_c_q;
  assign halted      = halted_q;
  assign instr_done  = instr_done_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: one early-end instance and one full-length
// instance share inputs; a ROM array answers each instance's address.
module tb_ucode_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step_req, alu_zero, alu_carry;
  logic [3:0]  opcode;

  logic [8:0]  addr1, addr0;
  logic [15:0] data1, data0, ctrl1, ctrl0;
  logic [2:0]  step1, step0;
  logic        fz1, fc1, hlt1, done1, fz0, fc0, hlt0, done0;
  logic [7:0]  cnt1, cnt0;

  logic [15:0] rom [0:511];

  assign data1 = rom[addr1];
  assign data0 = rom[addr0];

  always #5 clk = ~clk;

  ucode_sequencer #(.EARLY_END(1'b1)) dut1 (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .opcode(opcode),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .ucode_addr(addr1),
    .ucode_data(data1), .ctrl(ctrl1), .step(step1), .flag_z(fz1), .flag_c(fc1),
    .halted(hlt1), .instr_done(done1), .instr_count(cnt1)
  );

  ucode_sequencer #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .step_req(step_req), .opcode(opcode),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .ucode_addr(addr0),
    .ucode_data(data0), .ctrl(ctrl0), .step(step0), .flag_z(fz0), .flag_c(fc0),
    .halted(hlt0), .instr_done(done0), .instr_count(cnt0)
  );

  int          checks = 0;
  int          fails  = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  task automatic expect_val(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
    // opcode 1: early-end program
    rom[9'h008] = 16'h4044; rom[9'h009] = 16'h1C08;
    rom[9'h00A] = 16'h4800; rom[9'h00B] = 16'h1200;
    // opcode 2: FI at step 4, ends at step 5
    for (int s = 0; s < 4; s++) rom[9'h010 + s] = 16'h0100;
    rom[9'h014] = 16'h0001;
    // opcode 3: halt at step 2
    rom[9'h018] = 16'h0100; rom[9'h019] = 16'h0100; rom[9'h01A] = 16'h8000;
    // opcode 4: FI on step 7
    for (int s = 0; s < 7; s++) rom[9'h020 + s] = 16'h0100;
    rom[9'h027] = 16'h0001;
    // opcode 5: three-cycle instruction
    rom[9'h028] = 16'h0100; rom[9'h029] = 16'h0100;

    reset = 1'b1; run = 1'b1; step_req = 1'b0; opcode = 4'h1;
    alu_zero = 1'b0; alu_carry = 1'b0;
    tick();
    tick();

    // Reset state, with run=1 held during reset
    expect_val("rst_step", 0);   check(step1);
    expect_val("rst_halt", 0);   check(hlt1);
    expect_val("rst_done", 0);   check(done1);
    expect_val("rst_cnt", 0);    check(cnt1);
    expect_val("rst_flags", 0);  check({fz1, fc1});
    expect_val("rst_ctrl", 0);   check(ctrl1);
    reset = 1'b0;
    #1;
    expect_val("run_ctrl_s0", 16'h4044); check(ctrl1);

    // Early end vs full length on the same program
    for (int n = 1; n <= 16; n++) begin
      expect_val($sformatf("ee_step_%0d", n), n % 5);
      expect_val($sformatf("ee_done_%0d", n), (n % 5) == 0);
      expect_val($sformatf("ee_cnt_%0d", n), n / 5);
      expect_val($sformatf("fl_step_%0d", n), n % 8);
      expect_val($sformatf("fl_done_%0d", n), (n % 8) == 0);
      expect_val($sformatf("fl_cnt_%0d", n), n / 8);
      tick();
      check(step1); check(done1); check(cnt1);
      check(step0); check(done0); check(cnt0);
      if (n == 1) begin
        expect_val("ctrl_s1", 16'h1C08); check(ctrl1);
      end
    end

    // Flag load on FI and flag-addressed next step
    run = 1'b0;
    do_reset();
    opcode = 4'h2; alu_zero = 1'b1; alu_carry = 1'b1; run = 1'b1;
    for (int n = 1; n <= 4; n++) tick();
    expect_val("fl_hold_flags", 2'b00); check({fz1, fc1});
    expect_val("fl_step4", 4);          check(step1);
    tick();
    expect_val("fl_loaded", 2'b11);     check({fz1, fc1});
    expect_val("fl_step5", 5);          check(step1);
    expect_val("fl_addr5", 9'b11_0010_101); check(addr1);
    tick();
    expect_val("fl_done", 1);           check(done1);
    expect_val("fl_addr_next", 9'b11_0010_000); check(addr1);
    run = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;

    // Halt
    do_reset();
    opcode = 4'h3; run = 1'b1;
    tick();
    tick();
    expect_val("hlt_ctrl_pre", 16'h8000); check(ctrl1);
    tick();
    expect_val("hlt_set", 1);   check(hlt1);
    expect_val("hlt_step", 2);  check(step1);
    for (int n = 0; n < 3; n++) begin
      expect_val("hlt_ctrl", 0); check(ctrl1);
      tick();
      expect_val("hlt_hold_step", 2); check(step1);
      expect_val("hlt_hold_done", 0); check(done1);
    end
    step_req = 1'b1; tick(); step_req = 1'b0; tick();
    expect_val("hlt_sticky", 1); check(hlt1);
    do_reset();
    expect_val("hlt_rst_step", 0); check(step1);
    expect_val("hlt_rst_halt", 0); check(hlt1);

    // Single-step with run=0
    run = 1'b0;
    tick();
    expect_val("ss_idle_step", 0); check(step1);
    expect_val("ss_idle_ctrl", 0); check(ctrl1);
    step_req = 1'b1;
    #1;
    expect_val("ss_pulse_ctrl", 16'h0100); check(ctrl1);
    for (int n = 0; n < 5; n++) tick();
    expect_val("ss_one_adv", 1);  check(step1);
    expect_val("ss_held_ctrl", 0); check(ctrl1);
    step_req = 1'b0;
    tick();
    step_req = 1'b1;
    tick();
    expect_val("ss_second", 2);   check(step1);
    expect_val("ss_not_halt", 0); check(hlt1);
    step_req = 1'b0;

    // Reset wins over FI + last step
    do_reset();
    opcode = 4'h4; alu_zero = 1'b1; alu_carry = 1'b1; run = 1'b1;
    for (int n = 0; n < 7; n++) tick();
    expect_val("rp_step7", 7); check(step1);
    reset = 1'b1;
    #1;
    expect_val("rp_ctrl", 0); check(ctrl1);
    tick();
    expect_val("rp_flags", 2'b00); check({fz1, fc1});
    expect_val("rp_step", 0);      check(step1);
    expect_val("rp_done", 0);      check(done1);
    expect_val("rp_cnt", 0);       check(cnt1);
    reset = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0; run = 1'b0;

    // Counter wrap after 256 instructions of three cycles
    do_reset();
    opcode = 4'h5; run = 1'b1;
    for (int n = 0; n < 255 * 3; n++) tick();
    expect_val("wr_cnt_ff", 8'hFF); check(cnt1);
    for (int n = 0; n < 3; n++) tick();
    expect_val("wr_cnt_00", 8'h00); check(cnt1);
    expect_val("wr_done", 1);       check(done1);
    run = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
